// File: rtl/price_fmt_pkg.sv
// Shared FSM encoding, ASCII constants and line-length helper for the price_line_fmt stream formatter.
package price_fmt_pkg;

    // Field order matters: the formatter steps to the next field by incrementing the state.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LABEL,
        ST_QTY,
        ST_INT,
        ST_DOT,
        ST_FRAC,
        ST_SIGN,
        ST_DONE
    } state_t;

    localparam logic [6:0] CH_T      = 7'h54;
    localparam logic [6:0] CH_O      = 7'h4F;
    localparam logic [6:0] CH_COLON  = 7'h3A;
    localparam logic [6:0] CH_DOT    = 7'h2E;
    localparam logic [6:0] CH_DOLLAR = 7'h24;
    localparam logic [6:0] CH_BLANK  = 7'h00;
    localparam logic [6:0] CH_ZERO   = 7'h30;

    function automatic int line_len(input int qty_digits, input int price_digits);
        return 4 + qty_digits + price_digits + 2;
    endfunction

endpackage

// File: rtl/bcd_ascii.sv
// One BCD digit to its ASCII code plus an invalid flag; callers decide how to show invalid digits.
module bcd_ascii
    import price_fmt_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] ascii_o,
    output logic       invalid_o
);

    assign invalid_o = (bcd_i > 4'd9);
    assign ascii_o   = CH_ZERO | {3'b000, bcd_i};

endmodule

// File: rtl/price_line_fmt.sv
// Streams one LCD price line as ASCII characters over valid/ready.
// Optional macro PRICE_LZB_EN: blank leading zeros of the integer price field.
module price_line_fmt
    import price_fmt_pkg::*;
#(
    parameter int PRICE_DIGITS = 4,
    parameter int FRAC_DIGITS  = 2,
    parameter int QTY_DIGITS   = 1,
    parameter int QTY_MAX      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    output logic                      ready_o,
    input  logic                      total_mode_i,
    input  logic [4*QTY_DIGITS-1:0]   qty_i,
    input  logic [4*PRICE_DIGITS-1:0] price_i,
    output logic [6:0]                char_o,
    output logic                      char_valid_o,
    input  logic                      char_ready_i,
    output logic                      char_last_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int LINE_LEN   = line_len(QTY_DIGITS, PRICE_DIGITS);
    localparam int INT_DIGITS = PRICE_DIGITS - FRAC_DIGITS;
    localparam int CNT_W      = $clog2(LINE_LEN);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      total_q, total_d;
    logic [4*QTY_DIGITS-1:0]   qty_q, qty_d;
    logic [4*PRICE_DIGITS-1:0] price_q, price_d;
    logic                      err_q, err_d;

    logic [3:0] price_dig [PRICE_DIGITS];
    logic [3:0] qty_dig   [QTY_DIGITS];

    for (genvar gi = 0; gi < PRICE_DIGITS; gi++) begin : g_price_dig
        assign price_dig[gi] = price_q[4*(PRICE_DIGITS-1-gi) +: 4];
    end
    for (genvar gi = 0; gi < QTY_DIGITS; gi++) begin : g_qty_dig
        assign qty_dig[gi] = qty_q[4*(QTY_DIGITS-1-gi) +: 4];
    end

    logic       beat, field_last, price_in_bad, qty_ok, blank_int;
    logic [3:0] conv_in;
    logic [6:0] conv_ch, digit_ch, char_c;
    logic       conv_bad;
    int         fpos, qty_idx, price_idx, field_len, qty_val;

    bcd_ascii u_conv (
        .bcd_i     (conv_in),
        .ascii_o   (conv_ch),
        .invalid_o (conv_bad)
    );
    assign digit_ch = conv_bad ? CH_BLANK : conv_ch;

    assign ready_o      = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign char_valid_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign char_last_o  = (state_q == ST_SIGN);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = (state_q == ST_DONE) && err_q;
    assign char_o       = char_c;
    assign beat         = char_valid_o && char_ready_i;

    // Error is known for the whole line at accept so DOT can be blanked before a bad FRAC digit is reached.
    always_comb begin
        price_in_bad = 1'b0;
        for (int i = 0; i < PRICE_DIGITS; i++) begin
            if (price_i[4*i +: 4] > 4'd9) price_in_bad = 1'b1;
        end
        qty_ok  = 1'b1;
        qty_val = 0;
        for (int i = 0; i < QTY_DIGITS; i++) begin
            if (qty_dig[i] > 4'd9) qty_ok = 1'b0;
            qty_val = qty_val * 10 + int'(qty_dig[i]);
        end
        qty_ok = qty_ok && (qty_val >= 1) && (qty_val <= QTY_MAX);
    end

    // LABEL and QTY form one 4+QTY_DIGITS wide field addressed by fpos.
    always_comb begin
        fpos      = (state_q == ST_QTY) ? int'(cnt_q) + 4 : int'(cnt_q);
        qty_idx   = total_q ? fpos - 4 : fpos;
        price_idx = (state_q == ST_FRAC) ? int'(cnt_q) + INT_DIGITS : int'(cnt_q);
        conv_in   = 4'd0;
        if (state_q == ST_LABEL || state_q == ST_QTY) begin
            for (int i = 0; i < QTY_DIGITS; i++) begin
                if (i == qty_idx) conv_in = qty_dig[i];
            end
        end else begin
            for (int i = 0; i < PRICE_DIGITS; i++) begin
                if (i == price_idx) conv_in = price_dig[i];
            end
        end
    end

`ifdef PRICE_LZB_EN
    logic int_lead_zero;
    always_comb begin
        int_lead_zero = 1'b1;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (i <= int'(cnt_q) && price_dig[i] != 4'd0) int_lead_zero = 1'b0;
        end
        blank_int = int_lead_zero && (int'(cnt_q) != INT_DIGITS - 1);
    end
`else
    assign blank_int = 1'b0;
`endif

    always_comb begin
        char_c = CH_BLANK;
        case (state_q)
            ST_LABEL, ST_QTY: begin
                if (total_q) begin
                    if (fpos < 4) begin
                        case (fpos)
                            0:       char_c = CH_T;
                            1:       char_c = CH_O;
                            2:       char_c = CH_T;
                            default: char_c = CH_COLON;
                        endcase
                    end else begin
                        char_c = digit_ch;
                    end
                end else if (qty_ok && fpos < QTY_DIGITS) begin
                    char_c = digit_ch;
                end
            end
            ST_INT:  char_c = blank_int ? CH_BLANK : digit_ch;
            ST_DOT:  char_c = err_q ? CH_BLANK : CH_DOT;
            ST_FRAC: char_c = digit_ch;
            ST_SIGN: char_c = err_q ? CH_BLANK : CH_DOLLAR;
            default: char_c = CH_BLANK;
        endcase
    end

    always_comb begin
        case (state_q)
            ST_LABEL: field_len = 4;
            ST_QTY:   field_len = QTY_DIGITS;
            ST_INT:   field_len = INT_DIGITS;
            ST_FRAC:  field_len = FRAC_DIGITS;
            default:  field_len = 1;
        endcase
        field_last = (int'(cnt_q) == field_len - 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        qty_d   = qty_q;
        price_d = price_q;
        err_d   = err_q;
        if (ready_o && start_i) begin
            state_d = ST_LABEL;
            cnt_d   = '0;
            total_d = total_mode_i;
            qty_d   = qty_i;
            price_d = price_i;
            err_d   = price_in_bad;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end else if (beat) begin
            if (field_last) begin
                state_d = state_t'(state_q + 3'd1);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            total_q <= 1'b0;
            qty_q   <= '0;
            price_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            qty_q   <= qty_d;
            price_q <= price_d;
            err_q   <= err_d;
        end
    end

endmodule
